asi_wburst_seq: RTL and testbench

- Write-burst sequencer for the ASI AXI slave write path.
- Accepts one AW command at a time (addr/len/size/burst/id).
- Expands the command into per-beat byte addresses and byte-lane masks for the W datapath and SRAM write port.
- Issues the B response once the last beat is consumed; flags illegal commands as SLVERR while still draining their W beats.

---
 rtl/asi_wburst_seq_pkg.sv | 37 +++
 rtl/asi_beat_addr_gen.sv | 54 +++++
 rtl/asi_wburst_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_asi_wburst_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asi_wburst_seq_pkg.sv
// Shared ASI definitions: bus widths, AXI burst/response codes and sequencer state encoding.
package asi_wburst_seq_pkg;

    localparam int unsigned AXI_AW     = 40;
    localparam int unsigned AXI_IW     = 8;
    localparam int unsigned AXI_LW     = 8;
    localparam int unsigned AXI_SW     = 3;
    localparam int unsigned AXI_DW     = 128;
    localparam int unsigned SLV_BYTES  = AXI_DW / 8;
    localparam int unsigned AXI_WSTRBW = SLV_BYTES;

    localparam logic [1:0] BT_FIXED = 2'b00;
    localparam logic [1:0] BT_INCR  = 2'b01;
    localparam logic [1:0] BT_WRAP  = 2'b10;
    localparam logic [1:0] BT_RSVD  = 2'b11;

    // WRAP length fields are beats-1
    localparam logic [AXI_LW-1:0] WRAP_BL_2  = AXI_LW'(1);
    localparam logic [AXI_LW-1:0] WRAP_BL_4  = AXI_LW'(3);
    localparam logic [AXI_LW-1:0] WRAP_BL_8  = AXI_LW'(7);
    localparam logic [AXI_LW-1:0] WRAP_BL_16 = AXI_LW'(15);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    function automatic logic wrap_len_legal(input logic [AXI_LW-1:0] len);
        return (len == WRAP_BL_2) || (len == WRAP_BL_4) ||
               (len == WRAP_BL_8) || (len == WRAP_BL_16);
    endfunction

endpackage

// File: rtl/asi_beat_addr_gen.sv
// Combinational beat address stepper and byte-lane mask calculator, shared by the
// read and write burst sequencers.
module asi_beat_addr_gen
    import asi_wburst_seq_pkg::*;
#(
    parameter int unsigned AW     = AXI_AW,
    parameter int unsigned SW     = AXI_SW,
    parameter int unsigned NBYTES = SLV_BYTES
) (
    input  logic [AW-1:0]     cur_addr,
    input  logic              first,
    input  logic [SW-1:0]     size,
    input  logic [1:0]        burst,
    input  logic [AW-1:0]     wrap_bound,
    input  logic [AW-1:0]     wrap_total,
    output logic [AW-1:0]     addr,
    output logic [NBYTES-1:0] mask
);

    localparam int unsigned LB = $clog2(NBYTES);

    logic [AW-1:0] step;
    logic [AW-1:0] aligned;
    logic [AW-1:0] inc;
    logic [31:0]   nbytes;
    logic [31:0]   lo;
    logic [31:0]   hi;

    // first=1 passes the start address through so beat 0 shares the mask logic
    always_comb begin
        step    = AW'(1) << size;
        aligned = cur_addr & ~(step - AW'(1));
        inc     = cur_addr + step;
        addr    = cur_addr;
        if (!first) begin
            unique case (burst)
                BT_INCR: addr = aligned + step;
                BT_WRAP: addr = (inc == wrap_bound + wrap_total) ? wrap_bound : inc;
                default: addr = cur_addr;
            endcase
        end
    end

    always_comb begin
        mask   = '0;
        nbytes = 32'd1 << size;
        lo     = 32'(addr[LB-1:0]);
        hi     = (lo & ~(nbytes - 32'd1)) + nbytes;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            mask[i] = (i >= lo) && (i < hi);
        end
    end

endmodule

// File: rtl/asi_wburst_seq.sv
// ASI AXI slave write-burst sequencer: expands an AW command into beat descriptors and
// issues the B response. Optional 4KB page-crossing check enabled by ASI_4KB_CHECK_EN.
module asi_wburst_seq
    import asi_wburst_seq_pkg::*;
(
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [AXI_IW-1:0]     aw_id,
    input  logic [AXI_AW-1:0]     aw_addr,
    input  logic [AXI_LW-1:0]     aw_len,
    input  logic [AXI_SW-1:0]     aw_size,
    input  logic [1:0]            aw_burst,
    output logic                  bt_valid,
    input  logic                  bt_ready,
    output logic [AXI_AW-1:0]     bt_addr,
    output logic [AXI_WSTRBW-1:0] bt_mask,
    output logic                  bt_last,
    output logic                  br_valid,
    input  logic                  br_ready,
    output logic [AXI_IW-1:0]     br_id,
    output logic [1:0]            br_resp,
    output logic                  busy
);

    state_e state_q, state_d;

    logic [AXI_IW-1:0]     id_q;
    logic [AXI_LW-1:0]     len_q;
    logic [AXI_SW-1:0]     size_q;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic [AXI_AW-1:0]     wbound_q;
    logic [AXI_AW-1:0]     wtotal_q;

    logic [AXI_LW-1:0]     cnt_q, cnt_d;
    logic                  aw_ready_q, aw_ready_d;
    logic                  bt_valid_q, bt_valid_d;
    logic [AXI_AW-1:0]     bt_addr_q, bt_addr_d;
    logic [AXI_WSTRBW-1:0] bt_mask_q, bt_mask_d;
    logic                  bt_last_q, bt_last_d;
    logic                  br_valid_q, br_valid_d;
    logic [AXI_IW-1:0]     br_id_q, br_id_d;
    logic [1:0]            br_resp_q, br_resp_d;
    logic                  busy_q, busy_d;

    logic aw_hs, bt_hs, br_hs, last_beat;
    logic [AXI_LW-1:0] cnt_inc;

    assign aw_hs     = aw_valid & aw_ready_q;
    assign bt_hs     = bt_valid_q & bt_ready;
    assign br_hs     = br_valid_q & br_ready;
    assign last_beat = (cnt_q == len_q);
    assign cnt_inc   = cnt_q + AXI_LW'(1);

    // Command decode
    logic [AXI_AW-1:0] aw_total;
    logic [AXI_AW-1:0] aw_bound;
    logic              aw_page_err;
    logic              aw_err;

    assign aw_total = (AXI_AW'(aw_len) + AXI_AW'(1)) << aw_size;
    assign aw_bound = aw_addr & ~(aw_total - AXI_AW'(1));

`ifdef ASI_4KB_CHECK_EN
    logic [AXI_AW-1:0] aw_step;
    logic [AXI_AW-1:0] aw_last_byte;

    assign aw_step      = AXI_AW'(1) << aw_size;
    assign aw_last_byte = (aw_addr & ~(aw_step - AXI_AW'(1))) + aw_total - AXI_AW'(1);
    assign aw_page_err  = (aw_burst == BT_INCR) &&
                          (aw_last_byte[AXI_AW-1:12] != aw_addr[AXI_AW-1:12]);
`else
    assign aw_page_err = 1'b0;
`endif

    assign aw_err = (aw_burst == BT_RSVD) ||
                    ((aw_burst == BT_WRAP) && !wrap_len_legal(aw_len)) ||
                    ((32'd1 << aw_size) > SLV_BYTES) ||
                    aw_page_err;

    // Address generator sees the raw command while idle and the latched one mid-burst
    logic                  gen_first;
    logic [AXI_AW-1:0]     gen_cur;
    logic [AXI_SW-1:0]     gen_size;
    logic [1:0]            gen_burst;
    logic [AXI_AW-1:0]     gen_bound;
    logic [AXI_AW-1:0]     gen_total;
    logic [AXI_AW-1:0]     gen_addr;
    logic [AXI_WSTRBW-1:0] gen_mask;

    always_comb begin
        gen_first = (state_q == S_IDLE);
        gen_cur   = bt_addr_q;
        gen_size  = size_q;
        gen_burst = burst_q;
        gen_bound = wbound_q;
        gen_total = wtotal_q;
        if (gen_first) begin
            gen_cur   = aw_addr;
            gen_size  = aw_size;
            gen_burst = aw_burst;
            gen_bound = aw_bound;
            gen_total = aw_total;
        end
    end

    asi_beat_addr_gen #(
        .AW     (AXI_AW),
        .SW     (AXI_SW),
        .NBYTES (SLV_BYTES)
    ) u_addr_gen (
        .cur_addr   (gen_cur),
        .first      (gen_first),
        .size       (gen_size),
        .burst      (gen_burst),
        .wrap_bound (gen_bound),
        .wrap_total (gen_total),
        .addr       (gen_addr),
        .mask       (gen_mask)
    );

    // FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (aw_hs) state_d = S_BURST;
            S_BURST: if (bt_hs && last_beat) state_d = S_RESP;
            S_RESP:  if (br_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs (next values of the registered outputs)
    always_comb begin
        cnt_d      = cnt_q;
        aw_ready_d = aw_ready_q;
        bt_valid_d = bt_valid_q;
        bt_addr_d  = bt_addr_q;
        bt_mask_d  = bt_mask_q;
        bt_last_d  = bt_last_q;
        br_valid_d = br_valid_q;
        br_id_d    = br_id_q;
        br_resp_d  = br_resp_q;
        busy_d     = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (aw_hs) begin
                    cnt_d      = '0;
                    aw_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    bt_valid_d = 1'b1;
                    bt_addr_d  = gen_addr;
                    bt_mask_d  = aw_err ? '0 : gen_mask;
                    bt_last_d  = (aw_len == '0);
                end
            end
            S_BURST: begin
                if (bt_hs) begin
                    if (last_beat) begin
                        bt_valid_d = 1'b0;
                        bt_mask_d  = '0;
                        bt_last_d  = 1'b0;
                        br_valid_d = 1'b1;
                        br_id_d    = id_q;
                        br_resp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        cnt_d     = cnt_inc;
                        bt_addr_d = gen_addr;
                        bt_mask_d = err_q ? '0 : gen_mask;
                        bt_last_d = (cnt_inc == len_q);
                    end
                end
            end
            S_RESP: begin
                if (br_hs) begin
                    br_valid_d = 1'b0;
                    aw_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q      <= '0;
            aw_ready_q <= 1'b1;
            bt_valid_q <= 1'b0;
            bt_addr_q  <= '0;
            bt_mask_q  <= '0;
            bt_last_q  <= 1'b0;
            br_valid_q <= 1'b0;
            br_id_q    <= '0;
            br_resp_q  <= RESP_OKAY;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            aw_ready_q <= aw_ready_d;
            bt_valid_q <= bt_valid_d;
            bt_addr_q  <= bt_addr_d;
            bt_mask_q  <= bt_mask_d;
            bt_last_q  <= bt_last_d;
            br_valid_q <= br_valid_d;
            br_id_q    <= br_id_d;
            br_resp_q  <= br_resp_d;
            busy_q     <= busy_d;
        end
    end

    // Command latch
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q     <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= BT_FIXED;
            err_q    <= 1'b0;
            wbound_q <= '0;
            wtotal_q <= '0;
        end else if (aw_hs) begin
            id_q     <= aw_id;
            len_q    <= aw_len;
            size_q   <= aw_size;
            burst_q  <= aw_burst;
            err_q    <= aw_err;
            wbound_q <= aw_bound;
            wtotal_q <= aw_total;
        end
    end

    assign aw_ready = aw_ready_q;
    assign bt_valid = bt_valid_q;
    assign bt_addr  = bt_addr_q;
    assign bt_mask  = bt_mask_q;
    assign bt_last  = bt_last_q;
    assign br_valid = br_valid_q;
    assign br_id    = br_id_q;
    assign br_resp  = br_resp_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_asi_wburst_seq.sv
// Directed scoreboard bench for asi_wburst_seq; expected beats/responses are queued at
// command issue and compared on every valid cycle (stalled cycles check stability).
module tb_asi_wburst_seq;
    import asi_wburst_seq_pkg::*;

    logic                  ACLK = 1'b0;
    logic                  ARESETn;
    logic                  aw_valid;
    logic                  aw_ready;
    logic [AXI_IW-1:0]     aw_id;
    logic [AXI_AW-1:0]     aw_addr;
    logic [AXI_LW-1:0]     aw_len;
    logic [AXI_SW-1:0]     aw_size;
    logic [1:0]            aw_burst;
    logic                  bt_valid;
    logic                  bt_ready;
    logic [AXI_AW-1:0]     bt_addr;
    logic [AXI_WSTRBW-1:0] bt_mask;
    logic                  bt_last;
    logic                  br_valid;
    logic                  br_ready;
    logic [AXI_IW-1:0]     br_id;
    logic [1:0]            br_resp;
    logic                  busy;

    typedef struct {
        logic [AXI_AW-1:0]     addr;
        logic [AXI_WSTRBW-1:0] mask;
        logic                  last;
        bit                    chk_addr;
    } beat_t;

    typedef struct {
        logic [AXI_IW-1:0] id;
        logic [1:0]        resp;
    } resp_t;

    beat_t exp_beats[$];
    resp_t exp_resp[$];

    int checks = 0;
    int errors = 0;
    bit stall  = 1'b0;

    asi_wburst_seq dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .aw_valid (aw_valid),
        .aw_ready (aw_ready),
        .aw_id    (aw_id),
        .aw_addr  (aw_addr),
        .aw_len   (aw_len),
        .aw_size  (aw_size),
        .aw_burst (aw_burst),
        .bt_valid (bt_valid),
        .bt_ready (bt_ready),
        .bt_addr  (bt_addr),
        .bt_mask  (bt_mask),
        .bt_last  (bt_last),
        .br_valid (br_valid),
        .br_ready (br_ready),
        .br_id    (br_id),
        .br_resp  (br_resp),
        .busy     (busy)
    );

    initial forever #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [AXI_AW-1:0] a, input logic [AXI_WSTRBW-1:0] m,
                             input logic l, input bit ca);
        beat_t b;
        b.addr = a; b.mask = m; b.last = l; b.chk_addr = ca;
        exp_beats.push_back(b);
    endtask

    task automatic push_resp(input logic [AXI_IW-1:0] id, input logic [1:0] r);
        resp_t e;
        e.id = id; e.resp = r;
        exp_resp.push_back(e);
    endtask

    // Called #1 after a rising edge
    task automatic send(input logic [AXI_IW-1:0] id, input logic [AXI_AW-1:0] a,
                        input logic [AXI_LW-1:0] l, input logic [AXI_SW-1:0] s,
                        input logic [1:0] b);
        int n = 0;
        while (!aw_ready && n < 50) begin
            @(posedge ACLK); #1; n++;
        end
        check("aw_ready_wait", aw_ready, 1'b1);
        aw_valid = 1'b1; aw_id = id; aw_addr = a; aw_len = l; aw_size = s; aw_burst = b;
        @(posedge ACLK); #1;
        aw_valid = 1'b0;
        check("busy_after_aw", busy, 1'b1);
        check("aw_ready_after_aw", aw_ready, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge ACLK); #1;
            if (exp_beats.size() == 0 && exp_resp.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_aw_ready"}, aw_ready, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_aw_ready"}, aw_ready, 1'b1);
        check({tag, "_bt_valid"}, bt_valid, 1'b0);
        check({tag, "_bt_addr"}, bt_addr, '0);
        check({tag, "_bt_mask"}, bt_mask, '0);
        check({tag, "_bt_last"}, bt_last, 1'b0);
        check({tag, "_br_valid"}, br_valid, 1'b0);
        check({tag, "_br_id"}, br_id, '0);
        check({tag, "_br_resp"}, br_resp, 2'b00);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    // Ready drivers: always ready, or toggling every cycle while stall is set
    initial begin
        bt_ready = 1'b1;
        br_ready = 1'b1;
        forever begin
            @(posedge ACLK); #1;
            bt_ready = stall ? ~bt_ready : 1'b1;
            br_ready = stall ? ~br_ready : 1'b1;
        end
    end

    // Monitor: compare on every valid cycle, retire on handshake
    always @(negedge ACLK) begin
        beat_t eb;
        resp_t er;
        if (ARESETn === 1'b1) begin
            if (bt_valid) begin
                if (exp_beats.size() == 0) begin
                    check("bt_unexpected", bt_valid, 1'b0);
                end else begin
                    eb = exp_beats[0];
                    if (eb.chk_addr) check("bt_addr", bt_addr, eb.addr);
                    check("bt_mask", bt_mask, eb.mask);
                    check("bt_last", bt_last, eb.last);
                    if (bt_ready) void'(exp_beats.pop_front());
                end
            end
            if (br_valid) begin
                if (exp_resp.size() == 0) begin
                    check("br_unexpected", br_valid, 1'b0);
                end else begin
                    er = exp_resp[0];
                    check("br_id", br_id, er.id);
                    check("br_resp", br_resp, er.resp);
                    check("br_beats_drained", exp_beats.size(), 0);
                    if (br_ready) void'(exp_resp.pop_front());
                end
            end
        end
    end

    initial begin
        ARESETn = 1'b0;
        aw_valid = 1'b0; aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
        #22;
        check_reset_outputs("reset");
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // INCR aligned, full lanes
        push_beat(40'h100, 16'hFFFF, 1'b0, 1'b1);
        push_beat(40'h110, 16'hFFFF, 1'b0, 1'b1);
        push_beat(40'h120, 16'hFFFF, 1'b0, 1'b1);
        push_beat(40'h130, 16'hFFFF, 1'b1, 1'b1);
        push_resp(8'h11, RESP_OKAY);
        send(8'h11, 40'h100, 8'd3, 3'd4, BT_INCR);
        wait_done("incr_aligned");

        // INCR unaligned start
        push_beat(40'h103, 16'h0008, 1'b0, 1'b1);
        push_beat(40'h104, 16'h00F0, 1'b1, 1'b1);
        push_resp(8'h22, RESP_OKAY);
        send(8'h22, 40'h103, 8'd1, 3'd2, BT_INCR);
        wait_done("incr_unaligned");

        // WRAP 4 beats
        push_beat(40'h38, 16'h0F00, 1'b0, 1'b1);
        push_beat(40'h3C, 16'hF000, 1'b0, 1'b1);
        push_beat(40'h30, 16'h000F, 1'b0, 1'b1);
        push_beat(40'h34, 16'h00F0, 1'b1, 1'b1);
        push_resp(8'h33, RESP_OKAY);
        send(8'h33, 40'h38, 8'd3, 3'd2, BT_WRAP);
        wait_done("wrap4");

        // FIXED with ready toggling
        stall = 1'b1;
        push_beat(40'h40, 16'h00FF, 1'b0, 1'b1);
        push_beat(40'h40, 16'h00FF, 1'b0, 1'b1);
        push_beat(40'h40, 16'h00FF, 1'b1, 1'b1);
        push_resp(8'h44, RESP_OKAY);
        send(8'h44, 40'h40, 8'd2, 3'd3, BT_FIXED);
        wait_done("fixed_stall");
        stall = 1'b0;

        // Illegal commands: beats drained with no lanes, SLVERR
        push_beat('0, 16'h0000, 1'b0, 1'b0);
        push_beat('0, 16'h0000, 1'b1, 1'b0);
        push_resp(8'h55, RESP_SLVERR);
        send(8'h55, 40'h80, 8'd1, 3'd2, BT_RSVD);
        wait_done("err_rsvd");

        push_beat('0, 16'h0000, 1'b0, 1'b0);
        push_beat('0, 16'h0000, 1'b0, 1'b0);
        push_beat('0, 16'h0000, 1'b1, 1'b0);
        push_resp(8'h56, RESP_SLVERR);
        send(8'h56, 40'h40, 8'd2, 3'd2, BT_WRAP);
        wait_done("err_wrap_len");

        push_beat('0, 16'h0000, 1'b0, 1'b0);
        push_beat('0, 16'h0000, 1'b1, 1'b0);
        push_resp(8'h57, RESP_SLVERR);
        send(8'h57, 40'h0, 8'd1, 3'd5, BT_INCR);
        wait_done("err_size");

        // INCR crossing a 4KB page
`ifdef ASI_4KB_CHECK_EN
        push_beat(40'hFF0, 16'h0000, 1'b0, 1'b1);
        push_beat(40'h1000, 16'h0000, 1'b1, 1'b1);
        push_resp(8'h66, RESP_SLVERR);
`else
        push_beat(40'hFF0, 16'hFFFF, 1'b0, 1'b1);
        push_beat(40'h1000, 16'hFFFF, 1'b1, 1'b1);
        push_resp(8'h66, RESP_OKAY);
`endif
        send(8'h66, 40'hFF0, 8'd1, 3'd4, BT_INCR);
        wait_done("page_cross");

        // Single-beat burst
        push_beat(40'h208, 16'h0300, 1'b1, 1'b1);
        push_resp(8'h77, RESP_OKAY);
        send(8'h77, 40'h208, 8'd0, 3'd1, BT_INCR);
        wait_done("single");

        // Reset while beat 2 is presented
        for (int i = 0; i < 8; i++) begin
            push_beat(40'h200 + 40'(i * 16), 16'hFFFF, (i == 7), 1'b1);
        end
        push_resp(8'h88, RESP_OKAY);
        send(8'h88, 40'h200, 8'd7, 3'd4, BT_INCR);
        for (int i = 0; i < 50 && exp_beats.size() > 6; i++) begin
            @(posedge ACLK); #1;
        end
        check("pre_reset_beats_left", exp_beats.size(), 6);
        ARESETn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_beats.delete();
        exp_resp.delete();
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        check_reset_outputs("post_reset");

        push_beat(40'h500, 16'hFFFF, 1'b0, 1'b1);
        push_beat(40'h510, 16'hFFFF, 1'b1, 1'b1);
        push_resp(8'h99, RESP_OKAY);
        send(8'h99, 40'h500, 8'd1, 3'd4, BT_INCR);
        wait_done("after_reset");

        repeat (3) @(posedge ACLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
